rtc_display_scanner: RTL and testbench
======================================

// Module: rtc_display_scanner
// PURPOSE
//  Downstream consumer of the RTC controller's register memory read port (ADDreadreg/datamemoria).
//  Periodically walks the time/date registers, splits each packed-BCD byte into two ASCII digits.
//  Streams the digits, with slot indices, to the character buffer of the display stage.
//  Uses a valid/ready handshake, so the display side may stall the scan.
// PARAMETERS
//  NUM_REGS    9      registers scanned per frame, addresses 0..NUM_REGS-1 (max 16)
//  REFRESH_DIV 50000  clk cycles between refresh ticks (>=2)
//  BAD_CHAR    8'h3F  ASCII emitted for a nibble >9 ('?')
// PORTS
//  clk         in   1  system clock, rising edge
//  reset       in   1  synchronous, active-low reset
//  ADDreadreg  out  4  register memory read address
//  datamemoria in   8  register memory read data, valid 1 clk after ADDreadreg changes
//  char_valid  out  1  char_code/char_slot valid
//  char_ready  in   1  display side accepts when char_valid&&char_ready at posedge
//  char_slot   out  5  character slot index, 2*reg_index (+1 for low digit)
//  char_code   out  8  ASCII digit '0'..'9' or BAD_CHAR
//  frame_done  out  1  one-clk pulse after last character of a frame is accepted
//  bcd_err     out  1  set if any nibble of current frame >9; cleared at frame start
// BEHAVIOUR
//  - Reset (reset==0 at posedge): all outputs 0, FSM=IDLE, refresh counter=0, pending tick cleared.
//    Reset mid-frame aborts the frame; no frame_done is issued.
//  - Refresh counter: counts 0..REFRESH_DIV-1, wraps; tick = (count==REFRESH_DIV-1).
//    A tick while FSM!=IDLE sets one pending flag; further ticks are dropped.
//  - FSM states and transitions:
//    IDLE -> ADDR on tick or pending; clears pending, idx=0, bcd_err=0.
//    ADDR: drive ADDreadreg=idx, 1 clk -> WAIT.
//    WAIT: 1 clk memory latency -> CAPT.
//    CAPT: latch datamemoria into data_q, 1 clk -> HI.
//    HI: char_valid=1, char_slot=2*idx, char_code=asc(data_q[7:4]); stays until accepted -> LO.
//    LO: char_valid=1, char_slot=2*idx+1, char_code=asc(data_q[3:0]); on accept:
//      idx==NUM_REGS-1 -> DONE, else idx+1 -> ADDR.
//    DONE: frame_done=1 for 1 clk -> IDLE.
//  - asc(n) = 8'h30+n for n<=9, else BAD_CHAR and bcd_err<=1 (sticky within frame).
//  - Handshake: char_slot/char_code stable while char_valid && !char_ready; char_valid never drops
//    before acceptance. Back-to-back: HI->LO accept on consecutive clks allowed.
//  - ADDreadreg holds idx from ADDR through LO (memory may be read at any time by other ports).
//  - Minimum frame latency with char_ready=1: 5*NUM_REGS+1 clks from leaving IDLE to frame_done.
//  - Width rules: char_slot = {idx,lsb}, zero-extended to 5 bits; idx is 4 bits, no overflow for NUM_REGS<=16.
// STRUCTURE
//  - Shared package/header: state encodings (IDLE,ADDR,WAIT,CAPT,HI,LO,DONE), ASCII_ZERO=8'h30,
//    register index constants (SEG=0,MIN=1,HOR=2,DIA=3,MES=4,ANO=5,TSEG=6,TMIN=7,THOR=8).
//  - One sub-module: bcd_nibble_ascii (4-bit in -> 8-bit ASCII + err flag), instantiated twice or muxed.
//  - Refresh counter and FSM live in the top.
// TESTING
//  1 Reset held 3 clks mid-frame (in LO) -> all outputs 0 next clk; no frame_done; scan restarts only on next tick.
//  2 REFRESH_DIV=8, memory reg0=8'h59, char_ready=1 -> slot0 '5'(8'h35), slot1 '9'(8'h39); 5 clks per register.
//  3 reg2=8'h1A -> slot4 8'h31, slot5 8'h3F, bcd_err=1 until next frame start; other slots unaffected.
//  4 char_ready low 10 clks during HI of reg3 -> char_valid stays 1, slot6/code stable; no skipped/duplicate slots.
//  5 Two ticks during a stalled frame -> exactly one extra frame follows; frame_done pulses exactly twice.
//  6 Full frame NUM_REGS=9, char_ready=1 -> 18 chars, slots 0..17 in order, frame_done 46 clks after leaving IDLE.

Source files
------------

// File: rtl/rtc_display_scanner_pkg.sv
// Shared types and constants for the RTC display scanner.
package rtc_display_scanner_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWait,
    StCapt,
    StHi,
    StLo,
    StDone
  } scan_state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // RTC register map (read-port addresses)
  localparam logic [3:0] SEG  = 4'd0;
  localparam logic [3:0] MIN  = 4'd1;
  localparam logic [3:0] HOR  = 4'd2;
  localparam logic [3:0] DIA  = 4'd3;
  localparam logic [3:0] MES  = 4'd4;
  localparam logic [3:0] ANO  = 4'd5;
  localparam logic [3:0] TSEG = 4'd6;
  localparam logic [3:0] TMIN = 4'd7;
  localparam logic [3:0] THOR = 4'd8;

endpackage

// File: rtl/bcd_nibble_ascii.sv
// Converts one BCD nibble to its ASCII digit; non-decimal nibbles map to BAD_CHAR.
module bcd_nibble_ascii
  import rtc_display_scanner_pkg::*;
#(
  parameter logic [7:0] BAD_CHAR = 8'h3F
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii,
  output logic       err
);

  // Pure decode, no state
  always_comb begin
    err   = (nibble > 4'd9);
    ascii = err ? BAD_CHAR : (ASCII_ZERO + {4'h0, nibble});
  end

endmodule

// File: rtl/rtc_display_scanner.sv
// Periodically scans the RTC registers and streams their BCD digits as ASCII characters
// with slot indices over a valid/ready handshake.
module rtc_display_scanner
  import rtc_display_scanner_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 9,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter logic [7:0]  BAD_CHAR    = 8'h3F
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] ADDreadreg,
  input  logic [7:0] datamemoria,
  output logic       char_valid,
  input  logic       char_ready,
  output logic [4:0] char_slot,
  output logic [7:0] char_code,
  output logic       frame_done,
  output logic       bcd_err
);

  localparam int unsigned CntW    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [3:0]  LastIdx = 4'(NUM_REGS - 1);

  scan_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            tick;
  logic            pending_q, pending_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            bcd_err_q, bcd_err_d;

  logic [3:0]      nib;
  logic [7:0]      nib_ascii;
  logic            nib_err;

  assign tick = (cnt_q == CntW'(REFRESH_DIV - 1));

  // Free-running refresh divider
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Single converter shared by both digits: high nibble except while presenting the low digit
  assign nib = (state_q == StLo) ? data_q[3:0] : data_q[7:4];

  bcd_nibble_ascii #(
    .BAD_CHAR(BAD_CHAR)
  ) u_nibble (
    .nibble(nib),
    .ascii (nib_ascii),
    .err   (nib_err)
  );

  // Scan state and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
      bcd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      bcd_err_q <= bcd_err_d;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    idx_d      = idx_q;
    data_d     = data_q;
    bcd_err_d  = bcd_err_q;
    char_valid = 1'b0;
    char_slot  = '0;
    char_code  = '0;
    frame_done = 1'b0;

    // Ticks arriving while busy collapse into one deferred frame
    if (tick && (state_q != StIdle)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (tick || pending_q) begin
          state_d   = StAddr;
          pending_d = 1'b0;
          idx_d     = '0;
          bcd_err_d = 1'b0;
        end
      end
      StAddr: state_d = StWait;
      StWait: state_d = StCapt;
      StCapt: begin
        data_d  = datamemoria;
        state_d = StHi;
      end
      StHi: begin
        char_valid = 1'b1;
        char_slot  = {idx_q, 1'b0};
        char_code  = nib_ascii;
        if (nib_err) begin
          bcd_err_d = 1'b1;
        end
        if (char_ready) begin
          state_d = StLo;
        end
      end
      StLo: begin
        char_valid = 1'b1;
        char_slot  = {idx_q, 1'b1};
        char_code  = nib_ascii;
        if (nib_err) begin
          bcd_err_d = 1'b1;
        end
        if (char_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StAddr;
          end
        end
      end
      StDone: begin
        frame_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ADDreadreg = idx_q;
  assign bcd_err    = bcd_err_q;

endmodule

// File: tb/tb_rtc_display_scanner.sv
module tb_rtc_display_scanner;

  localparam int unsigned NumRegs    = 9;
  localparam int unsigned RefreshDiv = 8;
  localparam logic [7:0]  BadChar    = 8'h3F;
  localparam int          FrameLen   = 5 * NumRegs;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] ADDreadreg;
  logic [7:0] datamemoria = 8'h00;
  logic       char_valid;
  logic       char_ready = 1'b1;
  logic [4:0] char_slot;
  logic [7:0] char_code;
  logic       frame_done;
  logic       bcd_err;

  rtc_display_scanner #(
    .NUM_REGS   (NumRegs),
    .REFRESH_DIV(RefreshDiv),
    .BAD_CHAR   (BadChar)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ADDreadreg (ADDreadreg),
    .datamemoria(datamemoria),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_slot  (char_slot),
    .char_code  (char_code),
    .frame_done (frame_done),
    .bcd_err    (bcd_err)
  );

  always #5 clk = ~clk;

  // Register memory model: synchronous read, one clock of latency
  logic [7:0] mem [16];
  always @(posedge clk) datamemoria <= mem[ADDreadreg];

  typedef struct {
    logic [4:0] slot;
    logic [7:0] code;
    int         cyc;
  } exp_chr_t;

  typedef struct {
    bit err;
    int cyc;
  } exp_frm_t;

  exp_chr_t exp_q[$];
  exp_frm_t frm_q[$];

  int total = 0;
  int bad = 0;
  int frames_seen = 0;
  int cyc = 0;
  int rst_cnt = 0;
  int mode = 0;
  int stall_cnt = 0;

  function automatic logic [7:0] ref_asc(input logic [3:0] n);
    if (n <= 4'd9) return 8'(48 + int'(n));
    return BadChar;
  endfunction

  function automatic logic [7:0] rand_byte();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  // Expected stream for one frame: two digits per register in address order.
  // start >= 0: cycle on which the scan leaves idle, giving exact acceptance times.
  task automatic push_frame(input int start, input int done_cyc);
    exp_chr_t e;
    exp_frm_t f;
    logic [3:0] n;
    f.err = 1'b0;
    for (int r = 0; r < int'(NumRegs); r++) begin
      for (int d = 0; d < 2; d++) begin
        n      = (d == 0) ? mem[r][7:4] : mem[r][3:0];
        e.slot = 5'(2 * r + d);
        e.code = ref_asc(n);
        e.cyc  = (start >= 0) ? start + 3 + 5 * r + d : -1;
        if (n > 4'd9) f.err = 1'b1;
        exp_q.push_back(e);
      end
    end
    f.cyc = done_cyc;
    frm_q.push_back(f);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!frame_done && n < 2000);
    if (!frame_done) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: frame_done=%0b after %0d clks, required 1", frame_done, n);
    end
  endtask

  // Cycle count since reset release
  always @(posedge clk) begin
    if (!reset) begin
      cyc     <= 0;
      rst_cnt <= rst_cnt + 1;
    end else begin
      cyc     <= cyc + 1;
      rst_cnt <= 0;
    end
  end

  // Display-side ready generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1: begin
          if (char_valid && char_slot == 5'd6 && stall_cnt < 10) begin
            char_ready = 1'b0;
            stall_cnt++;
          end else begin
            char_ready = 1'b1;
          end
        end
        2: char_ready = ($urandom_range(0, 3) != 0);
        default: char_ready = 1'b1;
      endcase
      if (mode != 1) stall_cnt = 0;
    end
  end

  // Monitor: pops the scoreboard on each accepted character and frame_done pulse
  logic       p_valid = 1'b0;
  logic       p_ready = 1'b0;
  logic [4:0] p_slot = '0;
  logic [7:0] p_code = '0;
  bit         p_ok = 1'b0;
  exp_chr_t   mon_e;
  exp_frm_t   mon_f;

  always @(negedge clk) begin
    if (rst_cnt > 0) begin
      total++;
      if (char_valid || frame_done || bcd_err || ADDreadreg != 4'd0 || char_slot != 5'd0 ||
          char_code != 8'd0) begin
        bad++;
        $display("FAIL reset_outputs: valid=%0b done=%0b err=%0b addr=%0d slot=%0d code=%h, required all 0",
                 char_valid, frame_done, bcd_err, ADDreadreg, char_slot, char_code);
      end
    end else if (reset) begin
      if (p_ok && p_valid && !p_ready) begin
        total++;
        if (!char_valid || char_slot != p_slot || char_code != p_code) begin
          bad++;
          $display("FAIL stall_hold: valid=%0b slot=%0d code=%h, required 1 slot=%0d code=%h",
                   char_valid, char_slot, char_code, p_slot, p_code);
        end
      end
      if (char_valid && char_slot == 5'd0 && !(p_ok && p_valid && p_slot == 5'd0)) begin
        total++;
        if (bcd_err !== 1'b0) begin
          bad++;
          $display("FAIL err_clear_at_start: bcd_err=%0b, required 0", bcd_err);
        end
      end
      if (char_valid && char_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL char_unexpected: slot=%0d code=%h, required no character", char_slot,
                   char_code);
        end else begin
          mon_e = exp_q.pop_front();
          if (char_slot != mon_e.slot || char_code != mon_e.code ||
              (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
            bad++;
            $display("FAIL char: slot=%0d code=%h cyc=%0d, required slot=%0d code=%h cyc=%0d",
                     char_slot, char_code, cyc, mon_e.slot, mon_e.code, mon_e.cyc);
          end
        end
      end
      if (frame_done) begin
        frames_seen++;
        total++;
        if (frm_q.size() == 0) begin
          bad++;
          $display("FAIL frame_unexpected: frame_done=1 at cyc=%0d, required 0", cyc);
        end else begin
          mon_f = frm_q.pop_front();
          if (bcd_err != mon_f.err || (mon_f.cyc >= 0 && cyc != mon_f.cyc)) begin
            bad++;
            $display("FAIL frame: bcd_err=%0b cyc=%0d, required bcd_err=%0b cyc=%0d",
                     bcd_err, cyc, mon_f.err, mon_f.cyc);
          end
        end
      end
    end
    p_valid = char_valid;
    p_ready = char_ready;
    p_slot  = char_slot;
    p_code  = char_code;
    p_ok    = reset && (rst_cnt == 0);
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    mem[0] = 8'h59;
    mem[2] = 8'h1A;

    // First frame after reset, ready always high: exact timing
    mode  = 0;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    push_frame(RefreshDiv, RefreshDiv + FrameLen);
    reset = 1'b1;
    wait_done();

    // Pending-tick frame with a 10-clock stall on slot 6; all digits valid
    for (int i = 0; i < 16; i++) mem[i] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    push_frame(-1, RefreshDiv + FrameLen + 2 + FrameLen + 10);
    mode = 1;
    wait_done();

    // Random backpressure and random register contents
    mode = 2;
    repeat (6) begin
      for (int i = 0; i < 16; i++) mem[i] = rand_byte();
      push_frame(-1, -1);
      wait_done();
    end

    // Reset for 3 clocks while a low digit is presented
    for (int i = 0; i < 16; i++) mem[i] = rand_byte();
    push_frame(-1, -1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(char_valid && char_slot[0]) && n < 2000);
    if (!(char_valid && char_slot[0])) begin
      total++;
      bad++;
      $display("FAIL lo_timeout: low digit not seen after %0d clks, required within 2000", n);
    end
    reset = 1'b0;
    mode  = 0;
    exp_q.delete();
    frm_q.delete();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) mem[i] = rand_byte();
    push_frame(RefreshDiv, RefreshDiv + FrameLen);
    reset = 1'b1;
    wait_done();

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0 || frm_q.size() != 0 || frames_seen != 9) begin
      bad++;
      $display("FAIL leftover: chars=%0d frames_pending=%0d frames_seen=%0d, required 0 0 9",
               exp_q.size(), frm_q.size(), frames_seen);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
